// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit queue: parity encodings, FSM state type
// and parity helpers.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // The reserved encoding behaves exactly like "no parity".
    function automatic logic par_enabled(input logic [1:0] par);
        return (par != PAR_NONE) && (par != PAR_RSVD);
    endfunction

    function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] par);
        logic p;
        case (par)
            PAR_EVEN: p = ^d;
            PAR_ODD:  p = ~(^d);
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy counter; the head entry is always visible on dout.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [LW-1:0] LVL_ONE = LW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_push;
    logic             w_pop;

    // Reset blocks writes so nothing slips into storage while the queue is being cleared.
    assign w_push = resetn && push && (r_level != LW'(DEPTH));
    assign w_pop  = pop && (r_level != '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign level = r_level;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte-queued UART transmitter: a FIFO feeds a framing FSM that serialises start,
// data (LSB first), optional parity and one or two stop bits.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [31:0]              cfg_divider,
    input  logic [1:0]               cfg_parity,
    input  logic                     cfg_stop2,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic                     ser_tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     tx_done
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic [LW-1:0] w_level;
    logic [7:0]    w_head;
    logic          w_push;
    logic          w_pop;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_cnt;
    logic [31:0]   r_div;
    logic [1:0]    r_par;
    logic          r_stop2;
    logic          r_stopidx;
    logic          r_parbit;
    logic          r_ser;
    logic [7:0]    r_shift;
    logic [2:0]    r_bitidx;

    logic          w_bit_end;
    logic          w_last_stop;
    logic          w_load;
    logic          w_ser_nxt;
    logic          w_tx_done;

    assign in_ready = (w_level < LW'(DEPTH));
    assign w_push   = in_valid && in_ready;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (w_push),
        .din    (in_data),
        .pop    (w_pop),
        .dout   (w_head),
        .level  (w_level)
    );

    assign w_bit_end   = (r_cnt == r_div);
    assign w_last_stop = !r_stop2 || r_stopidx;

    // ser_tx is computed one cycle ahead so the line itself comes straight from a flop.
    always_comb begin
        w_state_nxt = r_state;
        w_ser_nxt   = r_ser;
        w_load      = 1'b0;
        w_tx_done   = 1'b0;
        case (r_state)
            IDLE: begin
                w_ser_nxt = 1'b1;
                if (w_level != '0) begin
                    w_load      = 1'b1;
                    w_state_nxt = START;
                    w_ser_nxt   = 1'b0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                    w_ser_nxt   = r_shift[0];
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bitidx != 3'd7) begin
                        w_ser_nxt = r_shift[1];
                    end else if (par_enabled(r_par)) begin
                        w_state_nxt = PARITY;
                        w_ser_nxt   = r_parbit;
                    end else begin
                        w_state_nxt = STOP;
                        w_ser_nxt   = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = STOP;
                    w_ser_nxt   = 1'b1;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_ser_nxt = 1'b1;
                    if (w_last_stop) begin
                        w_tx_done = 1'b1;
                        // Chain straight into the next frame when more bytes are waiting.
                        if (w_level != '0) begin
                            w_load      = 1'b1;
                            w_state_nxt = START;
                            w_ser_nxt   = 1'b0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_ser_nxt   = 1'b1;
            end
        endcase
    end

    assign w_pop = w_load;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_ser     <= 1'b1;
            r_cnt     <= '0;
            r_bitidx  <= '0;
            r_stopidx <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ser   <= w_ser_nxt;
            if (w_load) begin
                r_cnt     <= '0;
                r_bitidx  <= '0;
                r_stopidx <= 1'b0;
            end else if (r_state != IDLE) begin
                if (w_bit_end) begin
                    r_cnt <= '0;
                    if (r_state == DATA) r_bitidx  <= r_bitidx + 3'd1;
                    if (r_state == STOP) r_stopidx <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 32'd1;
                end
            end
        end
    end

    // Frame payload and configuration are captured at pop so mid-frame cfg changes are ignored.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_shift  <= w_head;
            r_div    <= cfg_divider;
            r_par    <= cfg_parity;
            r_stop2  <= cfg_stop2;
            r_parbit <= parity_bit(w_head, cfg_parity);
        end else if ((r_state == DATA) && w_bit_end) begin
            r_shift <= r_shift >> 1;
        end
    end

    assign ser_tx  = r_ser;
    assign tx_done = w_tx_done;
    assign busy    = (r_state != IDLE) || (w_level != '0);
    assign level   = w_level;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: a waveform-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_uart_tx_queue;

    localparam int DEPTH = 16;

    logic        clk;
    logic        resetn;
    logic [31:0] cfg_divider;
    logic [1:0]  cfg_parity;
    logic        cfg_stop2;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        ser_tx;
    logic        busy;
    logic [4:0]  level;
    logic        tx_done;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    uart_tx_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cfg_divider (cfg_divider),
        .cfg_parity  (cfg_parity),
        .cfg_stop2   (cfg_stop2),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .ser_tx      (ser_tx),
        .busy        (busy),
        .level       (level),
        .tx_done     (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Reference model: queued bytes plus the expected line waveform, one entry per cycle.
    typedef struct packed {
        logic ser;
        logic done;
    } cyc_t;

    logic [7:0] q[$];
    cyc_t       line[$];
    logic       m_ser   = 1'b1;
    logic       m_done  = 1'b0;
    logic       m_busy  = 1'b0;
    int         m_level = 0;
    logic       m_ready = 1'b1;

    always @(posedge clk) begin : model
        logic [7:0] d;
        logic       fb[12];
        int         nb;
        logic       acc;
        if (!resetn) begin
            q.delete();
            line.delete();
        end else begin
            acc = in_valid && (q.size() < DEPTH);
            if (line.size() > 0) void'(line.pop_front());
            if (line.size() == 0 && q.size() > 0) begin
                d = q.pop_front();
                fb[0] = 1'b0;
                for (int i = 0; i < 8; i++) fb[1 + i] = d[i];
                nb = 9;
                if (cfg_parity == 2'b01) begin fb[nb] = ^d;    nb++; end
                if (cfg_parity == 2'b10) begin fb[nb] = ~(^d); nb++; end
                fb[nb] = 1'b1; nb++;
                if (cfg_stop2) begin fb[nb] = 1'b1; nb++; end
                for (int b = 0; b < nb; b++)
                    for (int c = 0; c <= int'(cfg_divider); c++)
                        line.push_back('{ser: fb[b], done: (b == nb - 1) && (c == int'(cfg_divider))});
            end
            if (acc) q.push_back(in_data);
        end
        m_ser   = (line.size() > 0) ? line[0].ser : 1'b1;
        m_done  = (line.size() > 0) ? line[0].done : 1'b0;
        m_level = q.size();
        m_busy  = (line.size() > 0) || (q.size() > 0);
        m_ready = (q.size() < DEPTH);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_ser_tx", ser_tx, m_ser);
            check("cyc_tx_done", tx_done, m_done);
            check("cyc_busy", busy, m_busy);
            check("cyc_level", level, m_level);
            check("cyc_in_ready", in_ready, m_ready);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat;
        logic       took;
        int         acc;
        int         n;

        resetn = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        cfg_divider = 32'd0; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        adv(2);
        chk_en = 1'b1;
        check("rst_ser_tx", ser_tx, 1);
        check("rst_tx_done", tx_done, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_level", level, 0);
        resetn = 1'b1;
        adv(3);

        // 0x55, 87-cycle bits, 8N1
        cfg_divider = 32'd86; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        in_valid = 1'b1; in_data = 8'h55;
        adv(1);
        in_valid = 1'b0;
        check("s1_before_pop_ser", ser_tx, 1);
        check("s1_before_pop_level", level, 1);
        adv(1);
        check("s1_start_ser", ser_tx, 0);
        check("s1_start_level", level, 0);
        pat = 10'b10_1010_1010;
        adv(43);
        for (int k = 0; k < 10; k++) begin
            check("s1_bit", ser_tx, pat[k]);
            if (k < 9) adv(87);
        end
        adv(43);
        check("s1_tx_done_870", tx_done, 1);
        adv(1);
        check("s1_done_cleared", tx_done, 0);
        check("s1_busy_low", busy, 0);
        adv(3);

        // 0x07 with even then odd parity, 4-cycle bits
        for (int p = 0; p < 2; p++) begin
            cfg_divider = 32'd3; cfg_parity = (p == 0) ? 2'b01 : 2'b10;
            in_valid = 1'b1; in_data = 8'h07;
            adv(1);
            in_valid = 1'b0;
            adv(1);
            adv(37);
            check(p == 0 ? "s2_even_parity_bit" : "s2_odd_parity_bit", ser_tx, (p == 0) ? 1 : 0);
            adv(6);
            check("s2_tx_done_44", tx_done, 1);
            adv(1);
            check("s2_idle", busy, 0);
            adv(3);
        end

        // in_valid held high from idle with slow bits
        cfg_divider = 32'd1000; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        in_data = 8'h00; in_valid = 1'b1;
        acc = 0; n = 0;
        while (tx_done !== 1'b1 && n < 20000) begin
            took = in_ready;
            adv(1);
            n++;
            if (took) begin
                acc++;
                in_data = in_data + 8'd1;
            end
        end
        check("s3_cycles_to_tx_done", n, 10011);
        check("s3_accepted", acc, 17);
        check("s3_ready_low_full", in_ready, 0);
        check("s3_level_full", level, 16);
        adv(1);
        in_valid = 1'b0;
        check("s3_level_after_pop", level, 15);
        check("s3_ready_after_pop", in_ready, 1);
        resetn = 1'b0;
        adv(1);
        check("s3_rst_level", level, 0);
        check("s3_rst_busy", busy, 0);
        resetn = 1'b1;
        adv(3);

        // three back-to-back frames with two stop bits
        cfg_divider = 32'd3; cfg_parity = 2'b00; cfg_stop2 = 1'b1;
        in_valid = 1'b1; in_data = 8'hA0;
        adv(1);
        in_data = 8'hA1;
        adv(1);
        in_data = 8'hA2;
        adv(1);
        in_valid = 1'b0;
        adv(42);
        check("s4_first_done", tx_done, 1);
        adv(1);
        check("s4_no_gap_start", ser_tx, 0);
        check("s4_done_one_cycle", tx_done, 0);
        adv(87);
        check("s4_third_done", tx_done, 1);
        check("s4_busy_at_third_done", busy, 1);
        adv(1);
        check("s4_busy_fell", busy, 0);
        cfg_stop2 = 1'b0;
        adv(3);

        // reset during data bit 4 with three bytes queued
        cfg_divider = 32'd3; cfg_parity = 2'b00;
        in_valid = 1'b1; in_data = 8'h00;
        adv(1);
        in_data = 8'h01;
        adv(1);
        in_data = 8'h02;
        adv(1);
        in_data = 8'h03;
        adv(1);
        in_valid = 1'b0;
        check("s5_queued", level, 3);
        adv(19);
        check("s5_data_bit4_low", ser_tx, 0);
        resetn = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
        adv(1);
        resetn = 1'b1; in_valid = 1'b0;
        check("s5_abort_ser_high", ser_tx, 1);
        check("s5_abort_level", level, 0);
        check("s5_abort_busy", busy, 0);
        adv(60);
        check("s5_no_more_frames", busy, 0);
        adv(3);

        // divider change mid-frame, reserved parity code acts as none
        cfg_divider = 32'd3; cfg_parity = 2'b11; cfg_stop2 = 1'b0;
        in_valid = 1'b1; in_data = 8'h3C;
        adv(1);
        in_valid = 1'b0;
        adv(1);
        adv(10);
        cfg_divider = 32'd7; in_valid = 1'b1; in_data = 8'hC3;
        adv(1);
        in_valid = 1'b0;
        adv(28);
        check("s6_first_done_40", tx_done, 1);
        adv(1);
        check("s6_second_start", ser_tx, 0);
        adv(7);
        check("s6_start_still_low", ser_tx, 0);
        adv(1);
        check("s6_bit0_8cyc", ser_tx, 1);
        adv(71);
        check("s6_second_done_80", tx_done, 1);
        adv(1);
        check("s6_idle", busy, 0);
        adv(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, 2..256.
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
  clk  in  1  clock; all logic on rising edge.
  resetn  in  1  reset, synchronous, active-low.
  cfg_divider  in  32  bit period minus one, in clk cycles.
  cfg_parity  in  2  00 none, 01 even, 10 odd, 11 treated as none.
  cfg_stop2  in  1  1 = two stop bits, 0 = one.
  in_valid  in  1  producer has a byte.
  in_data  in  8  byte to send, LSB first on the line.
  in_ready  out  1  FIFO can accept; transfer when in_valid && in_ready.
  ser_tx  out  1  serial line, idle high.
  busy  out  1  frame in progress or FIFO non-empty.
  level  out  clog2(DEPTH)+1  FIFO occupancy.
  tx_done  out  1  one-cycle pulse when the final stop bit period ends.

Function
REQ-003 SHALL keep in_ready = (level < DEPTH), combinational from level only; a pop in the same cycle SHALL NOT raise in_ready.
REQ-004 SHALL push in_data on every edge with in_valid && in_ready; push and pop may occur on the same edge, leaving level unchanged.
REQ-005 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-006 IDLE with level>0 SHALL pop the head byte into the shift register, latch cfg_divider/cfg_parity/cfg_stop2, and enter START on the same edge.
REQ-007 Byte accepted on edge N into an empty FIFO with FSM in IDLE: pop SHALL occur on edge N+1, ser_tx low from edge N+1.
REQ-008 Each bit SHALL last exactly latched cfg_divider+1 cycles; cfg_divider=0 gives one cycle per bit.
REQ-009 Frame order SHALL be: start(0), data bits 0..7, parity bit if enabled, one or two stop bits (1).
REQ-010 Parity bit SHALL be XOR of data bits for even parity and its inverse for odd parity.
REQ-011 Changes to cfg_* during a frame SHALL NOT affect that frame.
REQ-012 At the end of the last stop bit, tx_done SHALL pulse for one cycle; if level>0 the next pop SHALL occur on that same edge (START follows with zero idle cycles), else the FSM SHALL go to IDLE.
REQ-013 busy SHALL be 1 when state != IDLE or level != 0.
REQ-014 ser_tx SHALL be a registered output with no combinational path from inputs.
REQ-015 Divider counter SHALL be 32 bits and compare by equality with the latched divider; it SHALL NOT wrap within a bit.

Reset
REQ-016 With resetn low at an edge: state IDLE, FIFO emptied (level 0), ser_tx 1, tx_done 0, busy 0, in_ready 1 after that edge.
REQ-017 Reset mid-frame SHALL abort the frame, with ser_tx high from the next edge; no partial byte is retained.
REQ-018 No push SHALL occur on an edge where resetn is low.

Structure
REQ-019 Package uart_pkg SHALL hold the parity encoding constants (PAR_NONE, PAR_EVEN, PAR_ODD) and the FSM state type.
REQ-020 FIFO storage and pointers SHALL be sub-module sync_fifo (DEPTH, WIDTH=8; push, pop, dout, level); uart_tx_queue holds the FSM, divider and shift logic.

Verification
REQ-021 Scenario: cfg_divider=86, no parity, one stop, push 0x55 -> ser_tx low at edge N+1, bits 0,1,0,1,0,1,0,1,0,1 each 87 cycles, tx_done at 870 cycles after the pop.
REQ-022 Scenario: cfg_divider=3, even parity, push 0x07 -> parity bit 1; odd parity -> 0; frame 11 bits x 4 cycles.
REQ-023 Scenario: cfg_divider=1000, DEPTH=16, in_valid held high from idle -> exactly 17 bytes accepted, then in_ready low until the first tx_done edge.
REQ-024 Scenario: push 0xA0,0xA1,0xA2 back-to-back with cfg_stop2=1 -> three frames, 2 stop bit periods each, no idle gap between frames, busy falls on the edge after the third tx_done.
REQ-025 Scenario: resetn low for 1 cycle during data bit 4 with 3 bytes queued -> ser_tx high next edge, level 0, no further frames.
REQ-026 Scenario: change cfg_divider 3->7 mid-frame -> current frame keeps 4-cycle bits, next frame uses 8-cycle bits.
